// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use interlock, branch flush, and data-memory wait
// handling with a stall timeout and a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [4:0]       i_rs1_addr_decode,
   input  logic [4:0]       i_rs2_addr_decode,
   input  logic             i_rs1_used_decode,
   input  logic             i_rs2_used_decode,
   input  logic [4:0]       i_rd_addr_execute,
   input  logic             i_rd_wren_execute,
   input  logic             i_mem_rden_execute,
   input  logic             i_br_taken_execute,
   input  logic             i_mem_req_mem,
   input  logic             i_dmem_ready,
   output logic             o_stall_fetch,
   output logic             o_stall_decode,
   output logic             o_stall_execute,
   output logic             o_stall_mem,
   output logic             o_flush_decode,
   output logic             o_flush_execute,
   output logic             o_mem_timeout,
   output logic [CNT_W-1:0] o_stall_cycles
);

   typedef enum logic [1:0] {RUN, MEMWAIT, ERROR} state_t;

   localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_reg;
   logic [7:0]       wait_cnt_reg;
   logic [CNT_W-1:0] stall_cycles_reg;
   logic             mem_stall;
   logic             load_use;

   always_comb begin
      mem_stall = i_mem_req_mem & ~i_dmem_ready;
      load_use  = i_mem_rden_execute & i_rd_wren_execute & (i_rd_addr_execute != 5'd0) &
                  ((i_rs1_used_decode & (i_rs1_addr_decode == i_rd_addr_execute)) |
                   (i_rs2_used_decode & (i_rs2_addr_decode == i_rd_addr_execute)));
   end

   // Zero-latency hazard response; reset masks everything regardless of inputs.
   always_comb begin
      o_stall_fetch   = 1'b0;
      o_stall_decode  = 1'b0;
      o_stall_execute = 1'b0;
      o_stall_mem     = 1'b0;
      o_flush_decode  = 1'b0;
      o_flush_execute = 1'b0;
      if (!i_reset) begin
         if (state_reg == ERROR || mem_stall) begin
            o_stall_fetch   = 1'b1;
            o_stall_decode  = 1'b1;
            o_stall_execute = 1'b1;
            o_stall_mem     = 1'b1;
         end else if (i_br_taken_execute) begin
            o_flush_decode  = 1'b1;
            o_flush_execute = 1'b1;
         end else if (load_use) begin
            o_stall_fetch   = 1'b1;
            o_stall_decode  = 1'b1;
            o_flush_execute = 1'b1;
         end
      end
   end

   assign o_mem_timeout  = (state_reg == ERROR) && !i_reset;
   assign o_stall_cycles = stall_cycles_reg;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg        <= RUN;
         wait_cnt_reg     <= 8'd0;
         stall_cycles_reg <= '0;
      end else begin
         if (o_stall_fetch && stall_cycles_reg != '1)
            stall_cycles_reg <= stall_cycles_reg + CNT_ONE;
         case (state_reg)
            RUN: begin
               wait_cnt_reg <= 8'd0;
               if (mem_stall) begin
                  state_reg    <= MEMWAIT;
                  wait_cnt_reg <= 8'd1;
               end
            end
            MEMWAIT: begin
               if (mem_stall) begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
                  if (wait_cnt_reg == WAIT_LAST)
                     state_reg <= ERROR;
               end else begin
                  state_reg    <= RUN;
                  wait_cnt_reg <= 8'd0;
               end
            end
            ERROR: state_reg <= ERROR;
            default: begin
               state_reg    <= RUN;
               wait_cnt_reg <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default instance scoreboarded, plus a short-timeout
// instance and a narrow-counter instance sharing the same stimulus.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic       u1 = 0, u2 = 0, wren = 0, rden = 0, br = 0, mreq = 0, rdy = 0;

   logic        sf, sd, se, sm, fd, fe, tmo;
   logic [15:0] cyc;
   logic        t_sf, t_sd, t_se, t_sm, t_fd, t_fe, t_tmo;
   logic [15:0] t_cyc;
   logic        s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_tmo;
   logic [2:0]  s_cyc;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .i_clk(clk), .i_reset(rst),
      .i_rs1_addr_decode(rs1), .i_rs2_addr_decode(rs2),
      .i_rs1_used_decode(u1), .i_rs2_used_decode(u2),
      .i_rd_addr_execute(rd), .i_rd_wren_execute(wren), .i_mem_rden_execute(rden),
      .i_br_taken_execute(br), .i_mem_req_mem(mreq), .i_dmem_ready(rdy),
      .o_stall_fetch(sf), .o_stall_decode(sd), .o_stall_execute(se), .o_stall_mem(sm),
      .o_flush_decode(fd), .o_flush_execute(fe), .o_mem_timeout(tmo), .o_stall_cycles(cyc));

   hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut_t (
      .i_clk(clk), .i_reset(rst),
      .i_rs1_addr_decode(rs1), .i_rs2_addr_decode(rs2),
      .i_rs1_used_decode(u1), .i_rs2_used_decode(u2),
      .i_rd_addr_execute(rd), .i_rd_wren_execute(wren), .i_mem_rden_execute(rden),
      .i_br_taken_execute(br), .i_mem_req_mem(mreq), .i_dmem_ready(rdy),
      .o_stall_fetch(t_sf), .o_stall_decode(t_sd), .o_stall_execute(t_se), .o_stall_mem(t_sm),
      .o_flush_decode(t_fd), .o_flush_execute(t_fe), .o_mem_timeout(t_tmo), .o_stall_cycles(t_cyc));

   hazard_ctrl #(.CNT_W(3)) dut_s (
      .i_clk(clk), .i_reset(rst),
      .i_rs1_addr_decode(rs1), .i_rs2_addr_decode(rs2),
      .i_rs1_used_decode(u1), .i_rs2_used_decode(u2),
      .i_rd_addr_execute(rd), .i_rd_wren_execute(wren), .i_mem_rden_execute(rden),
      .i_br_taken_execute(br), .i_mem_req_mem(mreq), .i_dmem_ready(rdy),
      .o_stall_fetch(s_sf), .o_stall_decode(s_sd), .o_stall_execute(s_se), .o_stall_mem(s_sm),
      .o_flush_decode(s_fd), .o_flush_execute(s_fe), .o_mem_timeout(s_tmo), .o_stall_cycles(s_cyc));

   // Control vector order: {stall_fetch, stall_decode, stall_execute, stall_mem, flush_decode, flush_execute}
   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_MEM  = 6'b111100;
   localparam logic [5:0] C_BR   = 6'b000011;
   localparam logic [5:0] C_LU   = 6'b110001;

   typedef struct {
      logic [5:0]  ctl;
      logic        tmo;
      logic [15:0] cyc;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] cyc_model = '0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock of stimulus; primary-instance expectations go through the scoreboard.
   task automatic step(input logic r, input logic [4:0] a1, input logic b1,
                       input logic [4:0] a2, input logic b2,
                       input logic [4:0] d, input logic we, input logic ld, input logic bt,
                       input logic mr, input logic rd_y, input logic [5:0] ectl, input string tag);
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst = r; rs1 = a1; u1 = b1; rs2 = a2; u2 = b2;
      rd = d; wren = we; rden = ld; br = bt; mreq = mr; rdy = rd_y;
      e.ctl = ectl; e.tmo = 1'b0; e.cyc = cyc_model; e.tag = tag;
      sb.push_back(e);
      #1;
      got = sb.pop_front();
      chk({got.tag, ".ctl"}, {10'd0, sf, sd, se, sm, fd, fe}, {10'd0, got.ctl});
      chk({got.tag, ".tmo"}, {15'd0, tmo}, {15'd0, got.tmo});
      chk({got.tag, ".cyc"}, cyc, got.cyc);
      $display("[TB] %s ctl=%b tmo=%b cyc=%0d", got.tag, {sf, sd, se, sm, fd, fe}, tmo, cyc);
      @(posedge clk);
      if (r) cyc_model = '0;
      else if (ectl[5] && cyc_model != 16'hFFFF) cyc_model = cyc_model + 16'd1;
   endtask

   initial begin
      @(posedge clk);
      // Reset masks a simultaneous memory stall and branch
      step(1, 0,0, 0,0, 0,0,0, 1, 1,0, C_NONE, "reset_masks");
      step(0, 0,0, 0,0, 0,0,0, 0, 0,1, C_NONE, "idle_after_reset");
      // Load-use on rs2
      step(0, 0,0, 5,1, 5,1,1, 0, 0,1, C_LU,   "load_use_rs2");
      step(0, 0,0, 5,1, 5,1,0, 0, 0,1, C_NONE, "after_bubble");
      step(0, 7,1, 0,0, 7,1,1, 0, 0,1, C_LU,   "load_use_rs1");
      // x0 destination and unused source never interlock
      step(0, 0,1, 0,1, 0,1,1, 0, 0,1, C_NONE, "x0_dest");
      step(0, 9,0, 0,0, 9,1,1, 0, 0,1, C_NONE, "rs1_unused");
      step(0, 9,1, 0,0, 9,0,1, 0, 0,1, C_NONE, "no_wren");
      // Branch beats load-use
      step(0, 0,0, 5,1, 5,1,1, 1, 0,1, C_BR,   "br_over_lu");
      // Memory wait of 3 cycles, branch suppressed until release
      step(1, 0,0, 0,0, 0,0,0, 0, 0,1, C_NONE, "reset2");
      step(0, 0,0, 0,0, 0,0,0, 0, 1,0, C_MEM,  "memwait1");
      step(0, 0,0, 5,1, 5,1,1, 1, 1,0, C_MEM,  "memwait2_br");
      step(0, 0,0, 0,0, 0,0,0, 1, 1,0, C_MEM,  "memwait3_br");
      chk("t_no_timeout_yet", {15'd0, t_tmo}, 16'd0);
      step(0, 0,0, 0,0, 0,0,0, 1, 1,1, C_BR,   "mem_release_br");
      step(0, 0,0, 0,0, 0,0,0, 0, 0,1, C_NONE, "cyc_after_wait");
      // Timeout on the short-timeout instance
      step(1, 0,0, 0,0, 0,0,0, 0, 0,1, C_NONE, "reset3");
      step(0, 0,0, 0,0, 0,0,0, 0, 1,0, C_MEM,  "to_stall1");
      step(0, 0,0, 0,0, 0,0,0, 0, 1,0, C_MEM,  "to_stall2");
      step(0, 0,0, 0,0, 0,0,0, 0, 1,0, C_MEM,  "to_stall3");
      step(0, 0,0, 0,0, 0,0,0, 0, 1,0, C_MEM,  "to_stall4");
      chk("t_tmo_before_4th_edge", {15'd0, t_tmo}, 16'd0);
      step(0, 0,0, 0,0, 0,0,0, 1, 0,1, C_BR,   "to_ready_br");
      chk("t_tmo_set", {15'd0, t_tmo}, 16'd1);
      chk("t_ctl_error", {10'd0, t_sf, t_sd, t_se, t_sm, t_fd, t_fe}, {10'd0, C_MEM});
      chk("t_cyc_error", t_cyc, 16'd4);
      step(0, 0,0, 0,0, 0,0,0, 0, 0,1, C_NONE, "to_sticky");
      chk("t_tmo_sticky", {15'd0, t_tmo}, 16'd1);
      chk("t_cyc_counts_in_error", t_cyc, 16'd5);
      step(1, 0,0, 0,0, 0,0,0, 0, 0,1, C_NONE, "to_reset");
      chk("t_tmo_in_reset", {15'd0, t_tmo}, 16'd0);
      chk("t_ctl_in_reset", {10'd0, t_sf, t_sd, t_se, t_sm, t_fd, t_fe}, 16'd0);
      step(0, 0,0, 0,0, 0,0,0, 0, 0,1, C_NONE, "to_after_reset");
      chk("t_tmo_cleared", {15'd0, t_tmo}, 16'd0);
      chk("t_ctl_run", {10'd0, t_sf, t_sd, t_se, t_sm, t_fd, t_fe}, 16'd0);
      // Saturation of the 3-bit counter over a 10-cycle stall
      step(1, 0,0, 0,0, 0,0,0, 0, 0,1, C_NONE, "reset4");
      for (int i = 0; i < 10; i++)
         step(0, 0,0, 0,0, 0,0,0, 0, 1,0, C_MEM, "sat_stall");
      step(0, 0,0, 0,0, 0,0,0, 0, 0,1, C_NONE, "sat_release");
      chk("s_cyc_saturated", {13'd0, s_cyc}, 16'd7);
      step(0, 0,0, 0,0, 0,0,0, 0, 0,1, C_NONE, "sat_hold");
      chk("s_cyc_holds", {13'd0, s_cyc}, 16'd7);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
